pipeline_wb_stage: RTL and testbench
====================================

PIPELINE_WB_STAGE -- requirements
Module: pipeline_wb_stage

Interface
REQ-001 SHALL have parameters (name, default, meaning): DW, 16, datapath width, a multiple of 8 and at least 16.
REQ-002 SHALL have parameter RW, 3, register index width.
REQ-003 SHALL have parameter LD_OP, 3'b011, opcode value identifying a load.
REQ-004 SHALL have parameter ZERO_RO, 0; when 1, writes to register 0 are suppressed.
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, in, 1, asynchronous active-low reset.
REQ-007 SHALL have ports in_valid, in, 1, upstream holds a valid instruction; and in_ready, out, 1, stage can accept this cycle.
REQ-008 SHALL have ports in_op, in, 3, opcode; in_wen, in, 1, register write enable; and in_wnum, in, RW, destination register index.
REQ-009 SHALL have ports in_result, in, DW, ALU result; in_B, in, DW, store operand; and in_ldmode, in, 2, load format.
REQ-010 SHALL have ports mem_rdata, in, DW, memory read data; and mem_rvalid, in, 1, memory read data valid this cycle.
REQ-011 SHALL have ports wb_en, out, 1; wb_num, out, RW; wb_data, out, DW; together forming the register-file write port.
REQ-012 SHALL have port delayed_B_out, out, DW, in_B of the instruction held in the stage.
REQ-013 SHALL have ports retired_cnt, out, 16, committed-instruction count; and stall_cnt, out, 16, load-wait cycle count.

Function
REQ-014 SHALL implement three states: EMPTY, ALU (holds non-load), LDW (holds load awaiting data).
REQ-015 SHALL define accept = in_valid && in_ready; on accept, SHALL capture op, wen, wnum, result, B and ldmode.
REQ-016 SHALL drive in_ready=1 in EMPTY and ALU, in LDW only when mem_rvalid=1, and 0 in LDW otherwise.
REQ-017 SHALL define commit = (state==ALU) || (state==LDW && mem_rvalid).
REQ-018 SHALL transition on a clock edge with accept to LDW if in_op==LD_OP, else to ALU.
REQ-019 SHALL transition to EMPTY on a clock edge with commit and no accept.
REQ-020 SHALL remain in LDW on a clock edge with no mem_rvalid, with all captured fields unchanged.
REQ-021 SHALL drive wb_en = commit && captured wen && !(ZERO_RO && captured wnum==0), combinationally from the stage register and mem_rvalid.
REQ-022 SHALL drive wb_num = captured wnum.
REQ-023 SHALL drive wb_data = captured result in ALU.
REQ-024 SHALL drive wb_data in LDW by ldmode: 00 mem_rdata; 01 mem_rdata[7:0] zero-extended to DW; 10 mem_rdata[7:0] sign-extended to DW; 11 mem_rdata[15:8] zero-extended to DW.
REQ-025 SHALL drive wb_data = 0 in EMPTY.
REQ-026 SHALL set ALU-instruction latency to 1: accepted at edge k, wb_en asserted in the cycle after edge k.
REQ-027 SHALL commit a load in the first cycle after acceptance in which mem_rvalid=1.
REQ-028 SHALL ignore mem_rvalid in EMPTY and ALU.
REQ-029 SHALL support commit and accept in the same cycle, giving back-to-back throughput of one instruction per cycle with no bubble.
REQ-030 SHALL increment retired_cnt by 1 on each commit edge, counting suppressed and wen=0 commits, and wrap 16'hFFFF to 0.
REQ-031 SHALL increment stall_cnt on each edge in LDW without mem_rvalid, saturating at 16'hFFFF.
REQ-032 SHALL drive delayed_B_out from the captured B, held while in LDW.

Reset
REQ-033 SHALL, while rst=0, asynchronously force state EMPTY, all captured fields 0, both counters 0, and hence wb_en=0, wb_num=0, wb_data=0, delayed_B_out=0, in_ready=1.
REQ-034 SHALL discard an instruction in LDW when rst is asserted mid-operation, with no write-back ever issued for it.
REQ-035 SHALL accept on the first rising edge after rst deasserts.

Verification
REQ-036 SHALL be verified by the ALU scenario: accept op=000, wen=1, wnum=5, result=16'h1234 at edge k -> in the next cycle wb_en=1, wb_num=5, wb_data=16'h1234, retired_cnt=1.
REQ-037 SHALL be verified by the load-stall scenario: accept load with ldmode=10, mem_rvalid low for 3 cycles then mem_rdata=16'h00F0 -> in_ready=0 for 3 cycles, stall_cnt=3, then wb_data=16'hFFF0 with wb_en=1.
REQ-038 SHALL be verified by the back-to-back scenario: 4 consecutive ALU instructions with in_valid held high -> in_ready stays 1, four consecutive wb_en pulses in order, retired_cnt=4.
REQ-039 SHALL be verified by the ZERO_RO scenario: ZERO_RO=1, ALU instruction with wnum=0 and wen=1 -> wb_en=0 while retired_cnt still increments.
REQ-040 SHALL be verified by the reset-mid-load scenario: rst asserted while in LDW, then mem_rvalid=1 after release -> no wb_en, counters 0, in_ready=1.
REQ-041 SHALL be verified by the wrap scenario: preload retired_cnt to 16'hFFFF via 65535 commits, one more commit -> retired_cnt=0.

Source files
------------

// File: rtl/pipeline_wb_stage.sv
// Write-back pipeline stage: one-entry stage register that commits ALU results
// after one cycle and waits for memory read data on loads, formatting the
// loaded value before it reaches the register-file write port.
module pipeline_wb_stage #(
  parameter int unsigned DW      = 16,
  parameter int unsigned RW      = 3,
  parameter logic [2:0]  LD_OP   = 3'b011,
  parameter bit          ZERO_RO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic          in_wen,
  input  logic [RW-1:0] in_wnum,
  input  logic [DW-1:0] in_result,
  input  logic [DW-1:0] in_B,
  input  logic [1:0]    in_ldmode,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          wb_en,
  output logic [RW-1:0] wb_num,
  output logic [DW-1:0] wb_data,
  output logic [DW-1:0] delayed_B_out,
  output logic [15:0]   retired_cnt,
  output logic [15:0]   stall_cnt
);

  // The opcode is captured in the form of the state: a load lands in ST_LDW,
  // anything else in ST_ALU.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ALU   = 2'b01,
    ST_LDW   = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          accept_s;
  logic          commit_s;
  logic          wen_r;
  logic [RW-1:0] wnum_r;
  logic [DW-1:0] result_r;
  logic [DW-1:0] b_r;
  logic [1:0]    ldmode_r;
  logic [15:0]   retired_r;
  logic [15:0]   stall_r;
  logic          wnum_zero_s;

  // State register; reset discards any held instruction, including a pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: a new instruction always wins; otherwise drain on commit.
  always_comb begin
    accept_s    = in_valid && in_ready;
    state_nxt_s = state_r;
    if (accept_s) begin
      if (in_op == LD_OP) begin
        state_nxt_s = ST_LDW;
      end else begin
        state_nxt_s = ST_ALU;
      end
    end else if (commit_s) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Outputs per state: readiness, commit and the formatted write-back data.
  always_comb begin
    in_ready = 1'b1;
    commit_s = 1'b0;
    wb_data  = {DW{1'b0}};
    case (state_r)
      ST_EMPTY: begin
        in_ready = 1'b1;
        commit_s = 1'b0;
        wb_data  = {DW{1'b0}};
      end
      ST_ALU: begin
        in_ready = 1'b1;
        commit_s = 1'b1;
        wb_data  = result_r;
      end
      ST_LDW: begin
        // A load can only be replaced in the same cycle its data arrives.
        in_ready = mem_rvalid;
        commit_s = mem_rvalid;
        case (ldmode_r)
          2'b00:   wb_data = mem_rdata;
          2'b01:   wb_data = {{(DW-8){1'b0}}, mem_rdata[7:0]};
          2'b10:   wb_data = {{(DW-8){mem_rdata[7]}}, mem_rdata[7:0]};
          2'b11:   wb_data = {{(DW-8){1'b0}}, mem_rdata[15:8]};
          default: wb_data = {DW{1'b0}};
        endcase
      end
      default: begin
        in_ready = 1'b1;
        commit_s = 1'b0;
        wb_data  = {DW{1'b0}};
      end
    endcase
  end

  // Register 0 may be read-only; its commits still retire but never write.
  assign wnum_zero_s   = (wnum_r == {RW{1'b0}});
  assign wb_en         = commit_s && wen_r && !((ZERO_RO == 1'b1) && wnum_zero_s);
  assign wb_num        = wnum_r;
  assign delayed_B_out = b_r;
  assign retired_cnt   = retired_r;
  assign stall_cnt     = stall_r;

  // Instruction fields: captured on accept, otherwise held (covers the load wait).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_r    <= 1'b0;
      wnum_r   <= {RW{1'b0}};
      result_r <= {DW{1'b0}};
      b_r      <= {DW{1'b0}};
      ldmode_r <= 2'b00;
    end else if (accept_s) begin
      wen_r    <= in_wen;
      wnum_r   <= in_wnum;
      result_r <= in_result;
      b_r      <= in_B;
      ldmode_r <= in_ldmode;
    end else begin
      wen_r    <= wen_r;
      wnum_r   <= wnum_r;
      result_r <= result_r;
      b_r      <= b_r;
      ldmode_r <= ldmode_r;
    end
  end

  // Retired counter counts every commit (suppressed or not) and wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_r <= 16'd0;
    end else if (commit_s) begin
      retired_r <= retired_r + 16'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Stall counter counts load-wait cycles and saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_r <= 16'd0;
    end else if ((state_r == ST_LDW) && !mem_rvalid && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Directed, scoreboard-based bench for pipeline_wb_stage. A second instance
// with ZERO_RO=1 shares all inputs with the main (ZERO_RO=0) instance.
module tb_pipeline_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = 3'd0;
  logic        in_wen = 1'b0;
  logic [2:0]  in_wnum = 3'd0;
  logic [15:0] in_result = 16'd0;
  logic [15:0] in_B = 16'd0;
  logic [1:0]  in_ldmode = 2'd0;
  logic [15:0] mem_rdata = 16'd0;
  logic        mem_rvalid = 1'b0;

  logic        in_ready, wb_en;
  logic [2:0]  wb_num;
  logic [15:0] wb_data, delayed_B_out, retired_cnt, stall_cnt;

  logic        in_ready_z, wb_en_z;
  logic [2:0]  wb_num_z;
  logic [15:0] wb_data_z, delayed_B_out_z, retired_cnt_z, stall_cnt_z;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;

  typedef struct packed {
    logic [2:0]  num;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  pipeline_wb_stage #(.DW(16), .RW(3), .LD_OP(3'b011), .ZERO_RO(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_wen(in_wen), .in_wnum(in_wnum), .in_result(in_result),
    .in_B(in_B), .in_ldmode(in_ldmode), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_en(wb_en), .wb_num(wb_num), .wb_data(wb_data), .delayed_B_out(delayed_B_out),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  pipeline_wb_stage #(.DW(16), .RW(3), .LD_OP(3'b011), .ZERO_RO(1'b1)) u_dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z),
    .in_op(in_op), .in_wen(in_wen), .in_wnum(in_wnum), .in_result(in_result),
    .in_B(in_B), .in_ldmode(in_ldmode), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_en(wb_en_z), .wb_num(wb_num_z), .wb_data(wb_data_z), .delayed_B_out(delayed_B_out_z),
    .retired_cnt(retired_cnt_z), .stall_cnt(stall_cnt_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [2:0] op, input logic wen, input logic [2:0] wnum,
                     input logic [15:0] res, input logic [15:0] b, input logic [1:0] ldm);
    in_valid  = 1'b1;
    in_op     = op;
    in_wen    = wen;
    in_wnum   = wnum;
    in_result = res;
    in_B      = b;
    in_ldmode = ldm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [2:0] num, input logic [15:0] data);
    sb_t it;
    it.num  = num;
    it.data = data;
    sb_q.push_back(it);
  endtask

  function automatic logic [15:0] fmt_load(input logic [1:0] m, input logic [15:0] d);
    logic [15:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = {8'h00, d[7:0]};
      2'b10:   r = {{8{d[7]}}, d[7:0]};
      default: r = {8'h00, d[15:8]};
    endcase
    return r;
  endfunction

  // Scoreboard monitor: every write-back pulse must match the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (wb_en === 1'b1) begin
      chk("wb_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        sb_t it;
        it = sb_q.pop_front();
        chk("wb_num", {29'd0, wb_num}, {29'd0, it.num});
        chk("wb_data", {16'd0, wb_data}, {16'd0, it.data});
      end
    end
  end

  initial begin
    // Reset held with a valid instruction on the inputs: nothing captured.
    drv(3'b000, 1'b1, 3'd7, 16'hAAAA, 16'hBBBB, 2'b00);
    mem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_num", {29'd0, wb_num}, 32'd0);
    chk("rst_wb_data", {16'd0, wb_data}, 32'd0);
    chk("rst_delayed_B", {16'd0, delayed_B_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_retired", {16'd0, retired_cnt}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);

    // ALU latency; accepted on the first edge after release.
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b0;
    drv(3'b000, 1'b1, 3'd5, 16'h1234, 16'h00AA, 2'b00);
    push(3'd5, 16'h1234);
    #2;
    chk("alu_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    idle();
    mem_rvalid = 1'b1;  // ignored while holding an ALU op
    mem_rdata  = 16'hDEAD;
    #2;
    chk("alu_wb_en", {31'd0, wb_en}, 32'd1);
    chk("alu_wb_data", {16'd0, wb_data}, 32'h1234);
    chk("alu_delayed_B", {16'd0, delayed_B_out}, 32'h00AA);
    exp_retired = 1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2;
    chk("alu_retired", {16'd0, retired_cnt}, exp_retired);
    chk("alu_empty_wb_en", {31'd0, wb_en}, 32'd0);
    chk("alu_empty_wb_data", {16'd0, wb_data}, 32'd0);

    // Load with three wait cycles, sign-extending byte format.
    @(negedge clk);
    drv(3'b011, 1'b1, 3'd2, 16'h0000, 16'h0BEE, 2'b10);
    #2;
    chk("ld_accept_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      mem_rdata = 16'h5555;
      #2;
      chk("ld_wait_ready", {31'd0, in_ready}, 32'd0);
      chk("ld_wait_wb_en", {31'd0, wb_en}, 32'd0);
      chk("ld_wait_delayed_B", {16'd0, delayed_B_out}, 32'h0BEE);
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h00F0;
    push(3'd2, 16'hFFF0);
    #2;
    chk("ld_data_ready", {31'd0, in_ready}, 32'd1);
    chk("ld_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("ld_wb_en", {31'd0, wb_en}, 32'd1);
    chk("ld_wb_data", {16'd0, wb_data}, 32'hFFF0);
    exp_retired++;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2;
    chk("ld_retired", {16'd0, retired_cnt}, exp_retired);
    chk("ld_stall_after", {16'd0, stall_cnt}, 32'd3);

    // All four load formats; mem_rvalid high while EMPTY must be ignored.
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      drv(3'b011, 1'b1, 3'(m + 1), 16'h0000, 16'h0000, 2'(m));
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
      #2;
      chk("fmt_accept_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      idle();
      mem_rdata = 16'hA5C3;
      push(3'(m + 1), fmt_load(2'(m), 16'hA5C3));
      exp_retired++;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2;
    chk("fmt_retired", {16'd0, retired_cnt}, exp_retired);

    // Back-to-back ALU instructions: no bubble, in-order write-backs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        drv(3'b001, 1'b1, 3'(i + 1), 16'h1000 + 16'(i), 16'h0000, 2'b00);
        push(3'(i + 1), 16'h1000 + 16'(i));
      end else begin
        idle();
      end
      #2;
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) begin
        chk("b2b_wb_en", {31'd0, wb_en}, 32'd1);
        chk("b2b_wb_en_z", {31'd0, wb_en_z}, 32'd1);
      end
    end
    exp_retired += 4;
    @(negedge clk);
    #2;
    chk("b2b_retired", {16'd0, retired_cnt}, exp_retired);

    // Register 0 write: suppressed only in the ZERO_RO instance.
    @(negedge clk);
    drv(3'b010, 1'b1, 3'd0, 16'h5555, 16'h0000, 2'b00);
    push(3'd0, 16'h5555);
    @(negedge clk);
    idle();
    #2;
    chk("zro_wb_en_z", {31'd0, wb_en_z}, 32'd0);
    chk("zro_wb_en_main", {31'd0, wb_en}, 32'd1);
    exp_retired++;
    @(negedge clk);
    #2;
    chk("zro_retired_z", {16'd0, retired_cnt_z}, exp_retired);
    chk("zro_retired", {16'd0, retired_cnt}, exp_retired);

    // Reset while a load waits; the late data must not produce a write-back.
    @(negedge clk);
    drv(3'b011, 1'b1, 3'd6, 16'h0000, 16'h0C0C, 2'b00);
    @(negedge clk);
    idle();
    #2;
    chk("rml_wait_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rml_async_ready", {31'd0, in_ready}, 32'd1);
    chk("rml_async_retired", {16'd0, retired_cnt}, 32'd0);
    chk("rml_async_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rml_async_delayed_B", {16'd0, delayed_B_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h1234;
    #2;
    chk("rml_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rml_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #2;
    chk("rml_retired", {16'd0, retired_cnt}, 32'd0);
    chk("rml_stall", {16'd0, stall_cnt}, 32'd0);

    // Retired counter wrap: 65535 commits, then one more.
    @(negedge clk);
    drv(3'b000, 1'b0, 3'd1, 16'h0000, 16'h0000, 2'b00);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    idle();
    @(negedge clk);
    #2;
    chk("wrap_full", {16'd0, retired_cnt}, 32'hFFFF);
    chk("wrap_full_z", {16'd0, retired_cnt_z}, 32'hFFFF);
    drv(3'b000, 1'b0, 3'd1, 16'h0000, 16'h0000, 2'b00);
    @(negedge clk);
    idle();
    @(negedge clk);
    #2;
    chk("wrap_zero", {16'd0, retired_cnt}, 32'd0);
    chk("wrap_zero_z", {16'd0, retired_cnt_z}, 32'd0);

    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
